fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes on input and output. It succeeds the combinational single-precision multiplier in the FPU. It adds configurable exponent/mantissa widths, four runtime rounding modes, full subnormal handling with correct rounding, and IEEE exception flags. It sits between the FPU operand issue logic and the result writeback path.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1); legal 5..11
MAN_W, 23, stored fraction width (significand = MAN_W+1 bits); legal 10..52
STAGES, 3, pipeline depth in cycles from input accept to output valid; legal 2..5

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
b  in  1+EXP_W+MAN_W  operand B
rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf); sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  1+EXP_W+MAN_W  product
flags  out  4  {NV invalid, OF overflow, UF underflow, NX inexact}, aligned with result

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, result=0, flags=0; in_ready=1 after release. Reset mid-operation discards all in-flight operations with no output.
- Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall. On stall every stage register holds, including result/flags. Otherwise all stages advance and bubbles propagate. No combinational path from in_valid to out_valid.
- Latency exactly STAGES cycles with no stall; throughput 1/cycle; results leave in acceptance order; no drops or duplicates.
- Stage 1: unpack, classify (zero/subnormal/normal/inf/NaN), form significands (implicit bit 0 for subnormal, effective exp 1), sign = sa^sb, and register the (2*MAN_W+2)-bit product plus the signed exponent sum ea+eb-bias (width EXP_W+3).
- Final stage: normalise (shift left by leading-zero count for subnormal products, or right by 1 if MSB set). If the biased exponent is <1, right-shift into subnormal range with all shifted-out bits ORed into sticky. Round once using guard/round/sticky per rnd_mode. A rounding carry-out increments the exponent; a carry from max subnormal yields min normal.
- Middle stages (STAGES>2) are pure retiming registers under the same stall.
- Specials, priority order:
  - any NaN, or inf*zero -> canonical qNaN {0, all-ones, 1, zeros}; NV=1 only for sNaN input or inf*zero.
  - inf*finite-nonzero -> signed inf.
  - zero*finite -> signed zero.
  - Special results have OF=UF=NX=0.
- Overflow (rounded exp >= all-ones): OF=NX=1.
  - RNE: signed inf.
  - RTZ: signed max finite.
  - RUP: +inf if positive, else -max finite.
  - RDN: -inf if negative, else +max finite.
- Underflow: UF=1 iff result is tiny before rounding AND inexact. Exact subnormal results set no flags. Total underflow rounds to zero or min subnormal per mode with UF=NX=1.
- NX=1 whenever any discarded bit is nonzero.

Test Plan:
- Default params, RNE: a=0x3FC00000 (1.5), b=0x40000000 (2.0) accepted cycle 0 -> out_valid cycle 3, result=0x40400000, flags=0000.
- a=0x7F800000, b=0x00000000 -> 0x7FC00000, NV=1; a=0xFF800000, b=0x40000000 -> 0xFF800000, flags=0.
- a=0x7F7FFFFF, b=0x40000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, RDN -> 0x7F7FFFFF; all with OF=NX=1.
- a=0x00800000, b=0x3F000000 -> 0x00400000, flags=0. a=0x00000001, b=0x3F000000: RNE -> 0x00000000, RUP -> 0x00000001; both UF=NX=1.
- Backpressure: 5 back-to-back products with out_ready low from cycle 2 to 8 -> in_ready low while stalled, result/flags stable, all 5 emerge in order, none lost or duplicated.
- Assert rst with 2 operations in flight -> out_valid=0 immediately; after release, no stale output appears. Repeat the first case with EXP_W=11, MAN_W=52: 0x3FF8000000000000 * 0x4000000000000000 -> 0x4008000000000000.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 binary multiplier with parametrised formats, four rounding modes,
// full subnormal support and exception flags; valid/ready on both sides, STAGES-cycle latency.
module fp_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [1:0]               rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SIG_W   = MAN_W + 1;
    localparam int PROD_W  = 2 * SIG_W;
    localparam int ES_W    = EXP_W + 3;
    localparam int XW      = EXP_W + 8;   // headroom for exponent minus a full-width leading-zero count
    localparam int LZ_W    = $clog2(PROD_W);
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rnd_e;

    typedef struct packed {
        logic              sign;
        rnd_e              rnd;
        logic              special;
        logic              spec_nv;
        logic [W-1:0]      spec_res;
        logic [PROD_W-1:0] prod;
        logic [ES_W-1:0]   exp_sum;
    } stage_t;

    // ---------------- stage 1: unpack, classify, multiply ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb, eff_ea, eff_eb;
    logic [MAN_W-1:0]   fa, fb;
    logic [SIG_W-1:0]   sig_a, sig_b;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_zero;
    stage_t             s1_d;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);

    // Subnormals carry no implicit one and share the exponent of the smallest normal.
    assign sig_a  = {ea != '0, fa};
    assign sig_b  = {eb != '0, fb};
    assign eff_ea = (ea == '0) ? EXP_W'(1) : ea;
    assign eff_eb = (eb == '0) ? EXP_W'(1) : eb;

    always_comb begin
        // NOTE: every field gets a default first so no path through the block leaves a latch.
        s1_d         = '0;
        s1_d.sign    = sa ^ sb;
        s1_d.rnd     = rnd_e'(rnd_mode);
        s1_d.prod    = PROD_W'(sig_a) * PROD_W'(sig_b);
        s1_d.exp_sum = ES_W'(eff_ea) + ES_W'(eff_eb) - ES_W'(BIAS);
        if (a_nan || b_nan || inf_zero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_nv  = a_snan || b_snan || inf_zero;
            s1_d.spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf || b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {sa ^ sb, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ---------------- pipeline registers ----------------
    logic              stall;
    logic [STAGES-2:0] vld;
    stage_t            pipe [STAGES-1];
    logic [W-1:0]      res_d;
    logic [3:0]        flags_d;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            for (int k = 1; k < STAGES - 1; k++) vld[k] <= vld[k-1];
            out_valid <= vld[STAGES-2];
            if (vld[STAGES-2]) begin
                result <= res_d;
                flags  <= flags_d;
            end
        end
    end

    // NOTE: payload registers are left unreset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pipe[0] <= s1_d;
            for (int k = 1; k < STAGES - 1; k++) pipe[k] <= pipe[k-1];
        end
    end

    // ---------------- final stage: normalise, denormalise, round ----------------
    stage_t              q;
    logic [LZ_W-1:0]     lz;
    logic [PROD_W-1:0]   norm;
    logic [XW-1:0]       exp_n, sh_full, sh, exp_f;
    logic                tiny, grd, rnd_bit, stk, inexact, round_up, ovf;
    logic [2*PROD_W-1:0] wide;
    logic [SIG_W-1:0]    kept;
    logic [SIG_W:0]      sig_r;

    assign q = pipe[STAGES-2];

    always_comb begin
        lz = '0;
        for (int i = 0; i < PROD_W; i++) begin
            if (q.prod[i]) lz = LZ_W'(PROD_W - 1 - i);
        end
        norm    = q.prod << lz;
        exp_n   = {{(XW-ES_W){q.exp_sum[ES_W-1]}}, q.exp_sum} + XW'(1) - XW'(lz);
        tiny    = exp_n[XW-1] || (exp_n == '0);
        sh_full = XW'(1) - exp_n;
        sh      = '0;
        if (tiny) sh = (sh_full > XW'(PROD_W)) ? XW'(PROD_W) : sh_full;

        // Bits pushed below the product window land in the low half and feed sticky.
        wide    = {norm, {PROD_W{1'b0}}} >> sh;
        kept    = wide[2*PROD_W-1 -: SIG_W];
        grd     = wide[PROD_W+MAN_W];
        rnd_bit = wide[PROD_W+MAN_W-1];
        stk     = |wide[PROD_W+MAN_W-2:0];
        inexact = grd || rnd_bit || stk;

        round_up = 1'b0;
        case (q.rnd)
            RNE: round_up = grd && (rnd_bit || stk || kept[0]);
            RTZ: round_up = 1'b0;
            RUP: round_up = inexact && !q.sign;
            RDN: round_up = inexact && q.sign;
            default: round_up = 1'b0;
        endcase

        // A carry into the implicit position turns the max subnormal into the min normal.
        sig_r = {1'b0, kept} + (SIG_W+1)'(round_up);
        exp_f = tiny ? XW'(sig_r[MAN_W]) : exp_n + XW'(sig_r[MAN_W+1]);
        ovf   = !tiny && (exp_f >= XW'(EXP_MAX));

        res_d   = {q.sign, exp_f[EXP_W-1:0], sig_r[MAN_W-1:0]};
        flags_d = {1'b0, 1'b0, tiny && inexact, inexact};

        if (ovf) begin
            flags_d = 4'b0101;
            if ((q.rnd == RTZ) || (q.rnd == RUP && q.sign) || (q.rnd == RDN && !q.sign))
                res_d = {q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else
                res_d = {q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end

        if (q.special) begin
            res_d   = q.spec_res;
            flags_d = {q.spec_nv, 3'b000};
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: single-precision instance for the main scenarios,
// double-precision instance for the wide-format case.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0, result;
    logic [1:0]  rnd_mode = 2'b00;
    logic [3:0]  flags;

    logic        d_in_valid = 1'b0, d_in_ready, d_out_valid;
    logic [63:0] d_a = '0, d_b = '0, d_result;
    logic [3:0]  d_flags;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t sb[$];
    out_t got_q[$];

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_mult_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(3)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .rnd_mode(2'b00), .out_valid(d_out_valid),
        .out_ready(1'b1), .result(d_result), .flags(d_flags)
    );

    // Output transfers are recorded mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({result, flags});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [1:0] rm, input out_t e);
        logic fire;
        fire = 1'b0;
        a = av; b = bv; rnd_mode = rm; in_valid = 1'b1;
        for (int i = 0; i < 100 && !fire; i++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (fire) sb.push_back(e);
        else begin
            n_total++;
            $display("FAIL send_accept: in_ready stayed 0, expected 1 within 100 cycles");
        end
    endtask

    task automatic wait_outputs(input int cycles);
        for (int i = 0; i < cycles && got_q.size() < sb.size(); i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
        n_total++; if (flags !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", flags); else n_pass++;
        n_total++; if (d_out_valid !== 1'b0) $display("FAIL reset_d_out_valid: got %b expected 0", d_out_valid); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int   lat;
        out_t e, g;
        send(32'h3FC00000, 32'h40000000, 2'b00, {32'h40400000, 4'b0000});
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++; if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat); else n_pass++;
        wait_outputs(20);
        while (sb.size() != 0) begin
            e = sb.pop_front(); g = '1;
            if (got_q.size() != 0) g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL basic: got %h/%b expected %h/%b", g.res, g.flg, e.res, e.flg);
            else n_pass++;
        end
    endtask

    task automatic test_specials();
        out_t e, g;
        send(32'h7F800000, 32'h00000000, 2'b00, {32'h7FC00000, 4'b1000});
        send(32'hFF800000, 32'h40000000, 2'b00, {32'hFF800000, 4'b0000});
        send(32'h7F800001, 32'h3F800000, 2'b00, {32'h7FC00000, 4'b1000});
        send(32'h7FC00001, 32'h40000000, 2'b00, {32'h7FC00000, 4'b0000});
        send(32'h80000000, 32'h40400000, 2'b00, {32'h80000000, 4'b0000});
        wait_outputs(20);
        while (sb.size() != 0) begin
            e = sb.pop_front(); g = '1;
            if (got_q.size() != 0) g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL specials: got %h/%b expected %h/%b", g.res, g.flg, e.res, e.flg);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        out_t e, g;
        send(32'h7F7FFFFF, 32'h40000000, 2'b00, {32'h7F800000, 4'b0101});
        send(32'h7F7FFFFF, 32'h40000000, 2'b01, {32'h7F7FFFFF, 4'b0101});
        send(32'h7F7FFFFF, 32'h40000000, 2'b11, {32'h7F7FFFFF, 4'b0101});
        send(32'h7F7FFFFF, 32'h40000000, 2'b10, {32'h7F800000, 4'b0101});
        send(32'hFF7FFFFF, 32'h40000000, 2'b10, {32'hFF7FFFFF, 4'b0101});
        wait_outputs(20);
        while (sb.size() != 0) begin
            e = sb.pop_front(); g = '1;
            if (got_q.size() != 0) g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL overflow: got %h/%b expected %h/%b", g.res, g.flg, e.res, e.flg);
            else n_pass++;
        end
    endtask

    task automatic test_subnormal();
        out_t e, g;
        send(32'h00800000, 32'h3F000000, 2'b00, {32'h00400000, 4'b0000});
        send(32'h00000001, 32'h3F000000, 2'b00, {32'h00000000, 4'b0011});
        send(32'h00000001, 32'h3F000000, 2'b10, {32'h00000001, 4'b0011});
        send(32'h80000001, 32'h3F000000, 2'b11, {32'h80000001, 4'b0011});
        send(32'h007FFFFF, 32'h3F800001, 2'b10, {32'h00800000, 4'b0011});
        wait_outputs(20);
        while (sb.size() != 0) begin
            e = sb.pop_front(); g = '1;
            if (got_q.size() != 0) g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL subnormal: got %h/%b expected %h/%b", g.res, g.flg, e.res, e.flg);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        out_t e, g, held;
        logic have_held;
        have_held = 1'b0;
        held = '0;
        fork
            for (int i = 0; i < 5; i++)
                send(32'h3F800000, 32'h40000000 + (i << 19), 2'b00, {32'h40000000 + (i << 19), 4'b0000});
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (7) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        n_total++;
                        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                        else n_pass++;
                        if (have_held) begin
                            n_total++;
                            if ({result, flags} !== held)
                                $display("FAIL stall_hold: got %h/%b expected %h/%b", result, flags, held.res, held.flg);
                            else n_pass++;
                        end
                        held = {result, flags};
                        have_held = 1'b1;
                    end
                end
                out_ready = 1'b1;
            end
        join
        wait_outputs(30);
        while (sb.size() != 0) begin
            e = sb.pop_front(); g = '1;
            if (got_q.size() != 0) g = got_q.pop_front();
            n_total++;
            if (g !== e) $display("FAIL back_to_back: got %h/%b expected %h/%b", g.res, g.flg, e.res, e.flg);
            else n_pass++;
        end
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 0) $display("FAIL back_to_back_extra: got %0d extra outputs expected 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_in_flight();
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 2'b00, {32'h40000000, 4'b0000});
        send(32'h3F800000, 32'h40400000, 2'b00, {32'h40400000, 4'b0000});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_flight_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL rst_flight_result: got %h expected 00000000", result); else n_pass++;
        sb.delete();
        got_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (got_q.size() != 0) $display("FAIL rst_flight_stale: got %0d outputs expected 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_double();
        int lat;
        n_total++; if (d_in_ready !== 1'b1) $display("FAIL double_in_ready: got %b expected 1", d_in_ready); else n_pass++;
        d_a = 64'h3FF8000000000000;
        d_b = 64'h4000000000000000;
        d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        lat = 1;
        while (!d_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++; if (lat !== 3) $display("FAIL double_latency: got %0d expected 3", lat); else n_pass++;
        n_total++;
        if (d_result !== 64'h4008000000000000) $display("FAIL double_result: got %h expected 4008000000000000", d_result);
        else n_pass++;
        n_total++; if (d_flags !== 4'b0) $display("FAIL double_flags: got %b expected 0000", d_flags); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_overflow();
        test_subnormal();
        test_back_to_back();
        test_reset_in_flight();
        test_double();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
